// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: Q-format defaults, multiplier latency and the complex sample type.
package fft_pkg;

  localparam int CMULT_LATENCY = 3;
  localparam int WORD_SIZE_DEF = 16;
  localparam int FRACTION_DEF  = 8;

  typedef struct packed {
    logic signed [WORD_SIZE_DEF-1:0] re;
    logic signed [WORD_SIZE_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_round_sat.sv
// Round-half-up and range reduction of one 2*WORD_SIZE+1 bit component down to WORD_SIZE bits.
// Define CMULT_SAT_EN to clamp out-of-range results and flag o_ovf; otherwise the result wraps.
module fft_round_sat
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int FRACTION  = FRACTION_DEF
) (
  input  logic signed [2*WORD_SIZE:0]  i_val,
  output logic signed [WORD_SIZE-1:0]  o_val,
  output logic                         o_ovf
);

  localparam int IW = 2*WORD_SIZE + 1;
  localparam logic signed [IW:0] HALF = (IW+1)'(1) << (FRACTION-1);

  // One guard bit above the input keeps the rounding add free of overflow.
  function automatic logic signed [IW:0] round_half_up(input logic signed [IW-1:0] v);
    return ((IW+1)'(v) + HALF) >>> FRACTION;
  endfunction

  logic signed [IW:0] shr;
  assign shr = round_half_up(i_val);

`ifdef CMULT_SAT_EN
  localparam logic signed [IW:0] MAXV = {{(IW+2-WORD_SIZE){1'b0}}, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [IW:0] MINV = ~MAXV;

  function automatic logic signed [WORD_SIZE:0] saturate(input logic signed [IW:0] v);
    if (v > MAXV)      return {1'b1, MAXV[WORD_SIZE-1:0]};
    else if (v < MINV) return {1'b1, MINV[WORD_SIZE-1:0]};
    else               return {1'b0, v[WORD_SIZE-1:0]};
  endfunction

  assign {o_ovf, o_val} = saturate(shr);
`else
  logic unused_hi;
  assign unused_hi = ^shr[IW:WORD_SIZE];
  assign o_val     = shr[WORD_SIZE-1:0];
  assign o_ovf     = 1'b0;
`endif

endmodule

// File: rtl/fft_cmult.sv
// Three-stage streamed signed complex multiplier P = A*B with a global-stall valid/ready handshake.
// Saturation instead of wrap-around is selected by defining CMULT_SAT_EN.
module fft_cmult
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int FRACTION  = FRACTION_DEF,
  parameter int TAG_W     = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [WORD_SIZE-1:0] i_a_re,
  input  logic signed [WORD_SIZE-1:0] i_a_im,
  input  logic signed [WORD_SIZE-1:0] i_b_re,
  input  logic signed [WORD_SIZE-1:0] i_b_im,
  input  logic        [TAG_W-1:0]     i_tag,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [WORD_SIZE-1:0] o_p_re,
  output logic signed [WORD_SIZE-1:0] o_p_im,
  output logic        [TAG_W-1:0]     o_tag,
  output logic                        o_ovf
);

  localparam int PW = 2*WORD_SIZE;

  logic advance;
  assign advance = i_ready | ~o_valid;
  assign o_ready = advance;

  // S1: operand and tag capture
  logic                        vld_p0;
  logic signed [WORD_SIZE-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0;
  logic        [TAG_W-1:0]     tag_p0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0  <= 1'b0;
      a_re_p0 <= '0;
      a_im_p0 <= '0;
      b_re_p0 <= '0;
      b_im_p0 <= '0;
      tag_p0  <= '0;
    end else if (advance) begin
      vld_p0  <= i_valid;
      a_re_p0 <= i_a_re;
      a_im_p0 <= i_a_im;
      b_re_p0 <= i_b_re;
      b_im_p0 <= i_b_im;
      tag_p0  <= i_tag;
    end
  end

  // S2: four full-precision partial products
  logic                 vld_p1;
  logic signed [PW-1:0] rr_p1, ii_p1, ri_p1, ir_p1;
  logic [TAG_W-1:0]     tag_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      rr_p1  <= '0;
      ii_p1  <= '0;
      ri_p1  <= '0;
      ir_p1  <= '0;
      tag_p1 <= '0;
    end else if (advance) begin
      vld_p1 <= vld_p0;
      rr_p1  <= PW'(a_re_p0) * PW'(b_re_p0);
      ii_p1  <= PW'(a_im_p0) * PW'(b_im_p0);
      ri_p1  <= PW'(a_re_p0) * PW'(b_im_p0);
      ir_p1  <= PW'(a_im_p0) * PW'(b_re_p0);
      tag_p1 <= tag_p0;
    end
  end

  // S3: combine, round, range-reduce and register the output beat
  logic signed [PW:0]          re_sum, im_sum;
  logic signed [WORD_SIZE-1:0] re_rnd, im_rnd;
  logic                        ovf_re, ovf_im;

  assign re_sum = (PW+1)'(rr_p1) - (PW+1)'(ii_p1);
  assign im_sum = (PW+1)'(ri_p1) + (PW+1)'(ir_p1);

  fft_round_sat #(.WORD_SIZE(WORD_SIZE), .FRACTION(FRACTION)) u_rs_re (
    .i_val (re_sum),
    .o_val (re_rnd),
    .o_ovf (ovf_re)
  );

  fft_round_sat #(.WORD_SIZE(WORD_SIZE), .FRACTION(FRACTION)) u_rs_im (
    .i_val (im_sum),
    .o_val (im_rnd),
    .o_ovf (ovf_im)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_p_re  <= '0;
      o_p_im  <= '0;
      o_tag   <= '0;
      o_ovf   <= 1'b0;
    end else if (advance) begin
      o_valid <= vld_p1;
      o_p_re  <= re_rnd;
      o_p_im  <= im_rnd;
      o_tag   <= tag_p1;
      o_ovf   <= ovf_re | ovf_im;
    end
  end

endmodule

// File: tb/tb_fft_cmult.sv
// Directed bench for fft_cmult with a queue scoreboard of expected output beats.
module tb_fft_cmult;
  import fft_pkg::*;

  localparam int W  = WORD_SIZE_DEF;
  localparam int F  = FRACTION_DEF;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, o_ready, o_valid, i_ready, o_ovf;
  logic [W-1:0]  a_re, a_im, b_re, b_im, p_re, p_im;
  logic [TW-1:0] tag, o_tag;

  always #5 clk = ~clk;

  fft_cmult #(.WORD_SIZE(W), .FRACTION(F), .TAG_W(TW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a_re  (a_re),
    .i_a_im  (a_im),
    .i_b_re  (b_re),
    .i_b_im  (b_im),
    .i_tag   (tag),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_p_re  (p_re),
    .o_p_im  (p_im),
    .o_tag   (o_tag),
    .o_ovf   (o_ovf)
  );

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [TW-1:0] tag;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_rs(input longint v, output logic ov);
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (W-1)) - 1;
    lo = -(longint'(1) <<< (W-1));
    r  = (v + (longint'(1) <<< (F-1))) >>> F;
    ov = 1'b0;
`ifdef CMULT_SAT_EN
    if (r > hi) begin ov = 1'b1; r = hi; end
    else if (r < lo) begin ov = 1'b1; r = lo; end
`else
    if (hi < lo) ov = 1'b1;
`endif
    return W'(r);
  endfunction

  function automatic exp_t model(input logic [W-1:0] ar, input logic [W-1:0] ai,
                                 input logic [W-1:0] br, input logic [W-1:0] bi,
                                 input logic [TW-1:0] tg);
    exp_t   e;
    longint vr, vi;
    logic   ovr, ovi;
    vr = longint'($signed(ar)) * longint'($signed(br)) - longint'($signed(ai)) * longint'($signed(bi));
    vi = longint'($signed(ar)) * longint'($signed(bi)) + longint'($signed(ai)) * longint'($signed(br));
    e.re  = model_rs(vr, ovr);
    e.im  = model_rs(vi, ovi);
    e.tag = tg;
    e.ovf = ovr | ovi;
    return e;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) begin
        exp_t e;
        chk("out_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_re",  32'(p_re),  32'(e.re));
          chk("sb_im",  32'(p_im),  32'(e.im));
          chk("sb_tag", 32'(o_tag), 32'(e.tag));
          chk("sb_ovf", 32'(o_ovf), 32'(e.ovf));
        end
      end
      if (i_valid && o_ready) sb.push_back(model(a_re, a_im, b_re, b_im, tag));
    end
  end

  task automatic set_beat(input logic [W-1:0] ar, input logic [W-1:0] ai,
                          input logic [W-1:0] br, input logic [W-1:0] bi, input logic [TW-1:0] tg);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; tag = tg;
  endtask

  task automatic single(input string name, input logic [W-1:0] ar, input logic [W-1:0] ai,
                        input logic [W-1:0] br, input logic [W-1:0] bi, input logic [TW-1:0] tg,
                        input logic [W-1:0] exp_re, input logic [W-1:0] exp_im, input logic exp_ovf);
    @(posedge clk); #1;
    set_beat(ar, ai, br, bi, tg);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (CMULT_LATENCY-1) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 32'(o_valid), 32'd1);
    chk({name, "_re"},    32'(p_re),    32'(exp_re));
    chk({name, "_im"},    32'(p_im),    32'(exp_im));
    chk({name, "_tag"},   32'(o_tag),   32'(tg));
    chk({name, "_ovf"},   32'(o_ovf),   32'(exp_ovf));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  hold_re, hold_im;
    logic [TW-1:0] hold_tag;
    logic [W-1:0]  bp_a[6];
    logic [W-1:0]  bp_b[6];
    int            sent, got, stall_left;
    logic          started, acc_in, acc_out;

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    set_beat('0, '0, '0, '0, '0);
    #2;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_re",    32'(p_re),    32'd0);
    chk("rst_im",    32'(p_im),    32'd0);
    chk("rst_tag",   32'(o_tag),   32'd0);
    chk("rst_ovf",   32'(o_ovf),   32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    single("basic",  16'h0100, 16'h0200, 16'h0300, 16'hFF00, 4'd5, 16'h0500, 16'h0500, 1'b0);
    single("rnd_up", 16'h0001, 16'h0000, 16'h0080, 16'h0000, 4'd1, 16'h0001, 16'h0000, 1'b0);
    single("rnd_0",  16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 4'd2, 16'h0000, 16'h0000, 1'b0);
    single("rnd_neg",16'hFFFF, 16'h0000, 16'h0180, 16'h0000, 4'd3, 16'hFFFF, 16'h0000, 1'b0);
`ifdef CMULT_SAT_EN
    single("corner", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 4'd4, 16'h7FFF, 16'h0000, 1'b1);
`else
    single("corner", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 4'd4, 16'h0000, 16'h0000, 1'b0);
`endif

    // Random back-to-back stream, checked through the scoreboard.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      set_beat(W'($urandom), W'($urandom), W'($urandom), W'($urandom), TW'(i));
      i_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Backpressure: stall four cycles once the second output is presented.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = W'($urandom);
      bp_b[i] = W'($urandom);
    end
    sent = 0; got = 0; stall_left = 0; started = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (!started && o_valid && got == 1) begin
        started = 1'b1; stall_left = 4;
        hold_re = p_re; hold_im = p_im; hold_tag = o_tag;
      end
      i_ready = (stall_left == 0);
      if (sent < 6) begin
        set_beat(bp_a[sent], bp_b[sent], bp_b[sent], bp_a[sent], TW'(sent));
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      if (stall_left > 0) begin
        chk("bp_ready_low", 32'(o_ready), 32'd0);
        chk("bp_hold_re",   32'(p_re),    32'(hold_re));
        chk("bp_hold_im",   32'(p_im),    32'(hold_im));
        chk("bp_hold_tag",  32'(o_tag),   32'(hold_tag));
        stall_left--;
      end
      acc_in  = i_valid && o_ready;
      acc_out = o_valid && i_ready;
      @(posedge clk); #1;
      if (acc_in)  sent++;
      if (acc_out) got++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("bp_stall_seen", 32'(started), 32'd1);
    chk("bp_out_count",  32'(got),     32'd6);
    repeat (3) @(posedge clk);

    // Bubbles: valid pattern 1,0,1 must reappear unchanged at the output.
    @(posedge clk); #1;
    set_beat(16'h0100, 16'h0000, 16'h0200, 16'h0000, 4'd10);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    set_beat(16'h0300, 16'h0000, 16'h0100, 16'h0000, 4'd11);
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("bub_v0",  32'(o_valid), 32'd1);
    chk("bub_t0",  32'(o_tag),   32'd10);
    @(negedge clk);
    chk("bub_v1",  32'(o_valid), 32'd0);
    @(negedge clk);
    chk("bub_v2",  32'(o_valid), 32'd1);
    chk("bub_t2",  32'(o_tag),   32'd11);
    repeat (3) @(posedge clk);

    // Reset with two beats in flight and the output stalled.
    @(posedge clk); #1;
    i_ready = 1'b0;
    set_beat(16'h0100, 16'h0100, 16'h0200, 16'h0100, 4'd12);
    i_valid = 1'b1;
    @(posedge clk); #1;
    set_beat(16'h0100, 16'h0100, 16'h0200, 16'h0100, 4'd13);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    chk("pre_rst_re",    32'(p_re),    32'h0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_re",    32'(p_re),    32'd0);
    chk("mid_rst_im",    32'(p_im),    32'd0);
    chk("mid_rst_tag",   32'(o_tag),   32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    sb.delete();
    i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(o_valid), 32'd0);
    end
    single("resume", 16'h0200, 16'h0000, 16'h0200, 16'h0000, 4'd7, 16'h0400, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
